// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned DEF_WIDTH = 8;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/seq_divider_ripple_sub.sv
// N-bit ripple subtractor a - b built from full-adder cells (inverted b, carry-in 1).
module ripple_sub
  import seq_divider_pkg::*;
#(
  parameter int unsigned N = DEF_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign {carry[i+1], diff[i]} = full_add(a[i], ~b[i], carry[i]);
  end

  assign borrow = ~carry[N];

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider with start/busy/done handshake; one subtract+shift per cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] d;
  logic             dz;

  logic [WIDTH:0]   shin;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             accept;
  logic             unused_msb;

  assign shin   = {r, q[WIDTH-1]};
  assign accept = start && (state != RUN);

  ripple_sub #(.N(WIDTH + 1)) u_sub (
    .a      (shin),
    .b      ({1'b0, d}),
    .diff   (trial),
    .borrow (borrow)
  );

  // The partial remainder always stays below the divisor, so WIDTH bits hold it.
  assign unused_msb = trial[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      q           <= '0;
      r           <= '0;
      d           <= '0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: ;
        RUN: begin
          if (!borrow) begin
            r <= trial[WIDTH-1:0];
            q <= {q[WIDTH-2:0], 1'b1};
          end else begin
            r <= shin[WIDTH-1:0];
            q <= {q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done        <= 1'b1;
          quotient    <= q;
          remainder   <= r;
          div_by_zero <= dz;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Zero divisor preloads the final answer and skips straight to DONE.
      if (accept) begin
        d   <= divisor;
        cnt <= '0;
        if (divisor == '0) begin
          q     <= '1;
          r     <= dividend;
          dz    <= 1'b1;
          state <= DONE;
        end else begin
          q     <= dividend;
          r     <= '0;
          dz    <= 1'b0;
          state <= RUN;
          busy  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, handshake corner cases, random vs. arithmetic model.
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the current sample point until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // One start pulse; returns latency and count of busy-profile violations.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_err);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    lat      = 0;
    busy_err = 0;
    while (!done && lat < 40) begin
      if (busy !== ((b != 0) && (lat < W))) busy_err++;
      tick();
      lat++;
    end
    if (busy !== 1'b0) busy_err++;
  endtask

  initial begin
    int lat;
    int lat2;
    int berr;
    int pulses;
    logic [W-1:0] cap_q;
    logic [W-1:0] cap_r;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] mq;
    logic [W-1:0] mr;

    vecs[0] = '{a: 200, b: 7,   q: 28,  r: 4,  dz: 1'b0, lat: 9};
    vecs[1] = '{a: 255, b: 1,   q: 255, r: 0,  dz: 1'b0, lat: 9};
    vecs[2] = '{a: 5,   b: 9,   q: 0,   r: 5,  dz: 1'b0, lat: 9};
    vecs[3] = '{a: 0,   b: 3,   q: 0,   r: 0,  dz: 1'b0, lat: 9};
    vecs[4] = '{a: 255, b: 255, q: 1,   r: 0,  dz: 1'b0, lat: 9};
    vecs[5] = '{a: 77,  b: 0,   q: 255, r: 77, dz: 1'b1, lat: 1};

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, berr);
      check($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].dz);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy_profile", i), berr, 0);
      tick();
      check($sformatf("vec%0d_done_one_cycle", i), done, 0);
    end

    // start while busy must be ignored
    dividend = 100; divisor = 3; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0; lat = 0; cap_q = '0; cap_r = '0;
    for (int n = 0; n < 25; n++) begin
      if (n == 3) begin
        dividend = 9; divisor = 2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        lat = n;
        cap_q = quotient;
        cap_r = remainder;
      end
      tick();
    end
    start = 1'b0;
    check("ignore_pulses", pulses, 1);
    check("ignore_latency", lat, 9);
    check("ignore_quotient", cap_q, 33);
    check("ignore_remainder", cap_r, 1);

    // start held high: back-to-back operations
    dividend = 100; divisor = 10; start = 1'b1;
    tick();
    dividend = 50; divisor = 7;
    wait_done(lat);
    check("b2b_first_latency", lat, 9);
    check("b2b_first_quotient", quotient, 10);
    check("b2b_first_remainder", remainder, 0);
    tick();
    wait_done(lat2);
    check("b2b_spacing", lat2 + 1, 9);
    check("b2b_second_quotient", quotient, 7);
    check("b2b_second_remainder", remainder, 1);
    start = 1'b0;
    repeat (12) tick();

    // reset in the middle of an iteration
    dividend = 200; divisor = 7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done) pulses++;
    end
    check("midrst_no_done", pulses, 0);
    run_op(13, 4, lat, berr);
    check("after_rst_quotient", quotient, 3);
    check("after_rst_remainder", remainder, 1);
    check("after_rst_latency", lat, 9);
    tick();

    // random operands against plain arithmetic
    for (int i = 0; i < 3000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 255));
      if (rb == 0) begin
        mq = '1;
        mr = ra;
      end else begin
        mq = ra / rb;
        mr = ra % rb;
      end
      run_op(ra, rb, lat, berr);
      check("rand_done_seen", done, 1);
      check("rand_quotient", quotient, mq);
      check("rand_remainder", remainder, mr);
      check("rand_dbz", div_by_zero, (rb == 0));
      check("rand_busy_profile", berr, 0);
      if (rb != 0) begin
        check("rand_identity", quotient * rb + remainder, ra);
        check("rand_rem_lt_div", remainder < rb, 1);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
